// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-queue slice.
//   BYTE_W      : width of one queued byte
//   txq_state_t : feeder FSM states
package uart_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } txq_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Byte FIFO with registered level/full/empty.
// Ports:
//   i_clk, i_rst  : clock, asynchronous active-high reset
//   i_wr_en       : write strobe; ignored while full
//   i_wr_data     : byte to store
//   i_rd_en       : pop strobe; ignored while empty
//   o_rd_data     : head byte (valid while !o_empty)
//   o_full        : DEPTH bytes held
//   o_empty       : no bytes held
//   o_level       : bytes held (0..DEPTH)
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic [BYTE_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic [BYTE_W-1:0] o_rd_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [AW:0]       o_level
);

    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [BYTE_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_level;
    logic              r_full;
    logic              r_empty;

    logic              w_push;
    logic              w_pop;
    logic [AW:0]       w_level_d;

    // A write while full is dropped even if a pop frees a slot this cycle.
    assign w_push = i_wr_en && !r_full;
    assign w_pop  = i_rd_en && !r_empty;

    always_comb begin
        w_level_d = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_d = r_level + 1'b1;
            2'b01:   w_level_d = r_level - 1'b1;
            default: w_level_d = r_level;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= w_level_d;
            r_full  <= (w_level_d == FULL_LEVEL);
            r_empty <= (w_level_d == '0);
        end
    end

    // Storage needs no reset; contents are meaningless while level is 0.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_full    = r_full;
    assign o_empty   = r_empty;
    assign o_level   = r_level;

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue plus feeder FSM in front of one UART transmitter channel.
// Host bursts bytes in; the feeder hands them to the transmitter one at a
// time over the send/data/ready handshake.
// Build option: define UART_TXQ_OVF_EN to enable the sticky overflow flag;
// otherwise o_ovf is tied low and i_ovf_clr is ignored.
// Ports:
//   i_clk, i_rst     : clock, asynchronous active-high reset
//   i_wr_en/i_wr_data: host byte write (dropped while o_full)
//   o_full, o_empty  : queue flags
//   o_level          : bytes queued (0..DEPTH)
//   o_uart_send      : one-cycle start pulse to transmitter
//   o_uart_tx_data   : byte for transmitter, updated only on a pop
//   i_uart_ready     : transmitter idle (1) / busy (0)
//   o_ovf, i_ovf_clr : sticky overflow flag and its clear
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic [BYTE_W-1:0] i_wr_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [AW:0]       o_level,
    output logic              o_uart_send,
    output logic [BYTE_W-1:0] o_uart_tx_data,
    input  logic              i_uart_ready,
    output logic              o_ovf,
    input  logic              i_ovf_clr
);

    txq_state_t        r_state;
    txq_state_t        w_state_d;
    logic              r_send;
    logic [BYTE_W-1:0] r_tx_data;
    logic              w_pop;
    logic [BYTE_W-1:0] w_head;
    logic              w_empty;
    logic              w_full;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (i_wr_en),
        .i_wr_data (i_wr_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (o_level)
    );

    always_comb begin
        w_state_d = r_state;
        w_pop     = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty && i_uart_ready) begin
                    w_pop     = 1'b1;
                    w_state_d = WAIT_BUSY;
                end
            end
            // Transmitter has not yet acknowledged the pulse by going busy.
            WAIT_BUSY: if (!i_uart_ready) w_state_d = WAIT_DONE;
            WAIT_DONE: if (i_uart_ready)  w_state_d = IDLE;
            default:   w_state_d = IDLE;
        endcase
    end

    // Send and data are registered together so the byte is valid for the
    // whole pulse cycle and held until the next pop.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_send    <= 1'b0;
            r_tx_data <= '0;
        end else begin
            r_state <= w_state_d;
            r_send  <= w_pop;
            if (w_pop) r_tx_data <= w_head;
        end
    end

    assign o_uart_send    = r_send;
    assign o_uart_tx_data = r_tx_data;
    assign o_full         = w_full;
    assign o_empty        = w_empty;

`ifdef UART_TXQ_OVF_EN
    logic r_ovf;

    // A dropped write in the same cycle as a clear leaves the flag set.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ovf <= 1'b0;
        end else if (i_wr_en && w_full) begin
            r_ovf <= 1'b1;
        end else if (i_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign o_ovf = r_ovf;
`else
    logic w_unused_ovf_clr;

    assign w_unused_ovf_clr = i_ovf_clr;
    assign o_ovf            = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: a queue-level model plus a simple
// behavioural transmitter; every negedge compares all outputs to the model.
module tb_uart_tx_queue;

    localparam int unsigned DEPTH = 16;
`ifdef UART_TXQ_OVF_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_wr_en;
    logic [7:0] i_wr_data;
    logic       o_full;
    logic       o_empty;
    logic [4:0] o_level;
    logic       o_uart_send;
    logic [7:0] o_uart_tx_data;
    logic       i_uart_ready;
    logic       o_ovf;
    logic       i_ovf_clr;

    uart_tx_queue #(.DEPTH(DEPTH)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_wr_en        (i_wr_en),
        .i_wr_data      (i_wr_data),
        .o_full         (o_full),
        .o_empty        (o_empty),
        .o_level        (o_level),
        .o_uart_send    (o_uart_send),
        .o_uart_tx_data (o_uart_tx_data),
        .i_uart_ready   (i_uart_ready),
        .o_ovf          (o_ovf),
        .i_ovf_clr      (i_ovf_clr)
    );

    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: queue contents and feeder readiness ----------------
    logic [7:0] m_q[$];
    logic [7:0] m_data    = 8'h00;
    logic       m_send    = 1'b0;
    logic       m_ovf     = 1'b0;
    logic       m_armed   = 1'b1;  // feeder free to start a new byte
    logic       m_seen_lo = 1'b0;  // transmitter has gone busy since last start

    initial forever begin
        @(posedge i_clk);
        if (i_rst) begin
            m_q.delete();
            m_data = 8'h00; m_send = 1'b0; m_ovf = 1'b0;
            m_armed = 1'b1; m_seen_lo = 1'b0;
        end else begin
            automatic bit was_full = (m_q.size() == DEPTH);
            automatic bit pop      = m_armed && (m_q.size() > 0) && i_uart_ready;
            automatic bit push     = i_wr_en && !was_full;
            if (OVF_EN) begin
                if (i_wr_en && was_full) m_ovf = 1'b1;
                else if (i_ovf_clr)      m_ovf = 1'b0;
            end
            if (!m_armed) begin
                if (!m_seen_lo) begin
                    if (!i_uart_ready) m_seen_lo = 1'b1;
                end else if (i_uart_ready) begin
                    m_armed = 1'b1;
                end
            end
            m_send = pop;
            if (pop) begin
                m_data    = m_q.pop_front();
                m_armed   = 1'b0;
                m_seen_lo = 1'b0;
            end
            if (push) m_q.push_back(i_wr_data);
        end
    end

    // ---------------- compare process + pulse log ----------------
    logic [7:0] sent[$];
    logic       tx_pulse_seen = 1'b0;

    initial forever begin
        @(negedge i_clk);
        tx_pulse_seen = o_uart_send;
        if (o_uart_send) sent.push_back(o_uart_tx_data);
        if (i_rst) begin
            chk("rst_level", o_level, 0);
            chk("rst_empty", o_empty, 1);
            chk("rst_full", o_full, 0);
            chk("rst_send", o_uart_send, 0);
            chk("rst_data", o_uart_tx_data, 0);
            chk("rst_ovf", o_ovf, 0);
        end else begin
            chk("level", o_level, m_q.size());
            chk("empty", o_empty, m_q.size() == 0);
            chk("full", o_full, m_q.size() == DEPTH);
            chk("send", o_uart_send, m_send);
            chk("tx_data", o_uart_tx_data, m_data);
            chk("ovf", o_ovf, m_ovf);
        end
    end

    // ---------------- behavioural transmitter ----------------
    int frame = 5;
    int busy  = 0;
    bit hold  = 1'b0;

    initial begin
        i_uart_ready = 1'b1;
        forever begin
            @(posedge i_clk);
            #1;
            if (tx_pulse_seen)  busy = frame;
            else if (busy > 0)  busy--;
            i_uart_ready = !hold && (busy == 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge i_clk);
        #2;
    endtask

    task automatic wr(input logic [7:0] b);
        i_wr_en = 1'b1; i_wr_data = b;
        step();
        i_wr_en = 1'b0;
    endtask

    task automatic set_hold(input bit v);
        hold = v;
        step();
        step();
    endtask

    task automatic wait_idle(input int budget);
        bit done = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (m_q.size() == 0 && m_armed && busy == 0 && i_uart_ready) begin
                done = 1'b1;
                break;
            end
            step();
        end
        chk("drain_in_time", done, 1);
    endtask

    task automatic wait_sent(input int n, input int budget);
        for (int c = 0; c < budget && sent.size() < n; c++) step();
        chk("pulses_in_time", sent.size(), n);
    endtask

    int base;
    int nw;
    bit wrote;

    initial begin
        i_rst = 1'b1; i_wr_en = 1'b0; i_wr_data = 8'h00; i_ovf_clr = 1'b0;
        step();
        step();
        chk("reset_empty", o_empty, 1);
        chk("reset_level", o_level, 0);
        chk("reset_send", o_uart_send, 0);
        i_rst = 1'b0;
        step();

        // 1: single byte, pulse the cycle after it lands
        frame = 5;
        wr(8'hA5);
        chk("t1_empty_after_wr", o_empty, 0);
        chk("t1_level_after_wr", o_level, 1);
        chk("t1_no_send_yet", o_uart_send, 0);
        step();
        chk("t1_send", o_uart_send, 1);
        chk("t1_data", o_uart_tx_data, 8'hA5);
        chk("t1_empty_after_pop", o_empty, 1);
        step();
        chk("t1_pulse_one_cycle", o_uart_send, 0);
        chk("t1_data_held", o_uart_tx_data, 8'hA5);
        wait_idle(100);

        // 2: three bytes, slow transmitter
        base = sent.size();
        frame = 100;
        set_hold(1'b1);
        wr(8'h01); wr(8'h02); wr(8'h03);
        chk("t2_level3", o_level, 3);
        hold = 1'b0;
        wait_sent(base + 3, 1000);
        wait_idle(300);
        chk("t2_b0", sent[base], 8'h01);
        chk("t2_b1", sent[base + 1], 8'h02);
        chk("t2_b2", sent[base + 2], 8'h03);
        chk("t2_level0", o_level, 0);

        // 3: overflow with transmitter held busy
        base = sent.size();
        frame = 3;
        set_hold(1'b1);
        for (int i = 0; i < DEPTH + 2; i++) wr(8'(8'h40 + i));
        chk("t3_full", o_full, 1);
        chk("t3_level16", o_level, 16);
        chk("t3_ovf_set", o_ovf, OVF_EN);
        i_wr_en = 1'b1; i_wr_data = 8'h52; i_ovf_clr = 1'b1;
        step();
        i_wr_en = 1'b0;
        chk("t3_set_beats_clr", o_ovf, OVF_EN);
        step();
        i_ovf_clr = 1'b0;
        chk("t3_ovf_cleared", o_ovf, 0);
        chk("t3_still16", o_level, 16);
        hold = 1'b0;
        wait_sent(base + DEPTH, 500);
        wait_idle(100);
        chk("t3_first", sent[base], 8'h40);
        chk("t3_last", sent[base + DEPTH - 1], 8'h4F);
        chk("t3_count", sent.size(), base + DEPTH);

        // 4: level 15 with write+pop together, across pointer wrap
        base = sent.size();
        set_hold(1'b1);
        for (int i = 0; i < 15; i++) wr(8'(8'h10 + i));
        chk("t4_level15", o_level, 15);
        hold = 1'b0;
        nw = 0;
        for (int c = 0; c < 2000 && nw < 22; c++) begin
            wrote = m_armed && (m_q.size() > 0) && i_uart_ready;
            i_wr_en = wrote; i_wr_data = 8'(8'h1F + nw);
            step();
            i_wr_en = 1'b0;
            if (wrote) begin
                nw++;
                chk("t4_level_stays15", o_level, 15);
            end
        end
        chk("t4_writes", nw, 22);
        wait_sent(base + 37, 1000);
        wait_idle(100);
        for (int i = 0; i < 37; i++) chk("t4_order", sent[base + i], 8'(8'h10 + i));

        // 5: reset while waiting for the transmitter with bytes queued
        base = sent.size();
        frame = 20;
        set_hold(1'b1);
        for (int i = 0; i < 6; i++) wr(8'(8'h60 + i));
        hold = 1'b0;
        for (int c = 0; c < 100 && sent.size() == base; c++) begin
            @(negedge i_clk);
            #1;
        end
        chk("t5_pulse_seen", sent.size(), base + 1);
        chk("t5_level5", o_level, 5);
        i_rst = 1'b1;
        #1;
        chk("t5_send_cleared", o_uart_send, 0);
        chk("t5_level_cleared", o_level, 0);
        chk("t5_empty", o_empty, 1);
        step();
        i_rst = 1'b0;
        wr(8'h77);
        wait_sent(base + 2, 200);
        wait_idle(100);
        chk("t5_first", sent[base], 8'h60);
        chk("t5_after_reset", sent[base + 1], 8'h77);
        chk("t5_count", sent.size(), base + 2);

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
